prbs_checker: RTL and testbench

Serial PRBS receiver/checker that pairs with the team's Fibonacci LFSR pattern generator. It self-synchronises to an incoming pseudo-random bit stream, declares lock after a run of correct predictions, then counts bit errors against its own free-running copy of the sequence. It sits at the receive end of link/loopback tests, after the deserialiser or pin sampler.

---
 rtl/prbs_checker.sv | 133 +++++++++++++
 tb/tb_prbs_checker.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker for the Fibonacci LFSR generator (next = {s, ^(s & TAPS)}).
// Define PRBS_CHK_BITCNT_EN to build the checked-bit counter; otherwise bit_cnt reads 0.
module prbs_checker #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
  parameter int               SYNC_CNT = 16,
  parameter int               LOSS_THR = 4,
  parameter int               ERR_W    = 16,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic             sync_lost,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(SYNC_CNT + 1);
  localparam int BW = $clog2(LOSS_THR + 1);

  typedef enum logic {SEARCH, LOCK} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] s_reg;
  logic [FW-1:0]    fill_reg;
  logic [MW-1:0]    match_reg;
  logic [BW-1:0]    bad_reg;

  logic             pred;
  logic             hit;
  logic [MW-1:0]    match_next;
  logic [BW-1:0]    bad_next;
  logic             err_inc;
  logic             bit_inc;

  assign pred    = ^(s_reg & TAPS);
  assign hit     = (in_bit == pred);
  assign err_inc = in_valid && (state_reg == LOCK) && !hit;
  assign bit_inc = in_valid && (state_reg == LOCK);

  // The all-zero register predicts zeros forever, so it never counts toward lock.
  always_comb begin
    match_next = '0;
    bad_next   = '0;
    if (hit && (|s_reg)) match_next = match_reg + MW'(1);
    if (!hit)            bad_next   = bad_reg + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= SEARCH;
      s_reg     <= '0;
      fill_reg  <= '0;
      match_reg <= '0;
      bad_reg   <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      err       <= 1'b0;
      sync_lost <= 1'b0;
      if (in_valid) begin
        case (state_reg)
          SEARCH: begin
            s_reg <= {s_reg[WIDTH-2:0], in_bit};
            if (fill_reg < FW'(WIDTH)) begin
              fill_reg <= fill_reg + FW'(1);
            end else if (match_next == MW'(SYNC_CNT)) begin
              state_reg <= LOCK;
              locked    <= 1'b1;
              match_reg <= '0;
              bad_reg   <= '0;
            end else begin
              match_reg <= match_next;
            end
          end
          LOCK: begin
            // Free-run on the prediction so one channel error gives one err pulse.
            s_reg <= {s_reg[WIDTH-2:0], pred};
            err   <= !hit;
            if (bad_next == BW'(LOSS_THR)) begin
              state_reg <= SEARCH;
              locked    <= 1'b0;
              sync_lost <= 1'b1;
              fill_reg  <= '0;
              match_reg <= '0;
              bad_reg   <= '0;
            end else begin
              bad_reg <= bad_next;
            end
          end
          default: state_reg <= SEARCH;
        endcase
      end
    end
  end

  // Clear and increment together leave the counter at 1.
  always_ff @(posedge clk) begin
    if (srst)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= ERR_W'(err_inc);
    else if (err_inc && !(&err_cnt))
      err_cnt <= err_cnt + ERR_W'(1);
  end

`ifdef PRBS_CHK_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt_reg;

  always_ff @(posedge clk) begin
    if (srst)
      bit_cnt_reg <= '0;
    else if (clr_cnt)
      bit_cnt_reg <= CNT_W'(bit_inc);
    else if (bit_inc && !(&bit_cnt_reg))
      bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
  end

  assign bit_cnt = bit_cnt_reg;
`else
  logic unused_bit_inc;
  assign unused_bit_inc = bit_inc;
  assign bit_cnt        = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker: two instances (ERR_W=16 and ERR_W=4) share one stimulus
// and are compared every cycle against a history-queue model of the checker's rules.
module tb_prbs_checker;

  localparam int         W    = 8;
  localparam logic [7:0] TAPS = 8'hB8;
  localparam int         SYNC = 16;
  localparam int         LOSS = 4;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        locked_a, err_a, lost_a;
  logic [15:0] ecnt_a;
  logic [31:0] bcnt_a;
  logic        locked_b, err_b, lost_b;
  logic [3:0]  ecnt_b;
  logic [31:0] bcnt_b;

  always #5 clk = ~clk;

  prbs_checker dut_a (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked_a), .err(err_a), .sync_lost(lost_a), .err_cnt(ecnt_a), .bit_cnt(bcnt_a)
  );

  prbs_checker #(.ERR_W(4)) dut_b (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked_b), .err(err_b), .sync_lost(lost_b), .err_cnt(ecnt_b), .bit_cnt(bcnt_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the last W received/predicted bits, newest at index 0.
  bit              hist[$];
  bit              m_locked, m_err, m_lost;
  int              m_fill, m_match, m_bad;
  longint unsigned m_ecnt, m_ecnt4, m_bcnt;

  function automatic bit predict();
    bit p = 1'b0;
    logic [7:0] taps = TAPS;
    for (int i = 0; i < W; i++)
      if (taps[i]) p ^= hist[i];
    return p;
  endfunction

  task automatic model_step(input bit rst, input bit v, input bit b, input bit clr);
    bit p, nonzero, inc_e, inc_b;
    inc_e  = 1'b0;
    inc_b  = 1'b0;
    m_err  = 1'b0;
    m_lost = 1'b0;
    if (rst) begin
      hist.delete();
      for (int i = 0; i < W; i++) hist.push_back(1'b0);
      m_locked = 1'b0;
      m_fill = 0; m_match = 0; m_bad = 0;
      m_ecnt = 0; m_ecnt4 = 0; m_bcnt = 0;
      return;
    end
    if (v) begin
      p = predict();
      nonzero = 1'b0;
      foreach (hist[i]) nonzero |= hist[i];
      if (!m_locked) begin
        hist.push_front(b);
        void'(hist.pop_back());
        if (m_fill < W) m_fill++;
        else begin
          m_match = (b == p && nonzero) ? m_match + 1 : 0;
          if (m_match == SYNC) begin
            m_locked = 1'b1; m_match = 0; m_bad = 0;
          end
        end
      end else begin
        hist.push_front(p);
        void'(hist.pop_back());
        inc_b = 1'b1;
        if (b != p) begin
          m_err = 1'b1; inc_e = 1'b1; m_bad++;
        end else m_bad = 0;
        if (m_bad == LOSS) begin
          m_lost = 1'b1; m_locked = 1'b0; m_fill = 0; m_match = 0; m_bad = 0;
        end
      end
    end
    if (clr) begin
      m_ecnt = inc_e; m_ecnt4 = inc_e; m_bcnt = inc_b;
    end else begin
      if (inc_e && m_ecnt < 65535) m_ecnt++;
      if (inc_e && m_ecnt4 < 15) m_ecnt4++;
      if (inc_b && m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
    end
`ifndef PRBS_CHK_BITCNT_EN
    m_bcnt = 0;
`endif
  endtask

  // Transmit-side generator, seeded 8'h01 after every reset scenario.
  logic [7:0] g;
  int         err_seen;
  bit         lock_seen;

  task automatic next_gen(output bit b);
    b = ^(g & TAPS);
    g = {g[6:0], b};
  endtask

  task automatic cyc(input bit v, input bit b, input bit clr, input bit rst);
    @(negedge clk);
    in_valid = v; in_bit = b; clr_cnt = clr; srst = rst;
    @(posedge clk);
    #1;
    model_step(rst, v, b, clr);
    chk("locked", locked_a, m_locked);
    chk("err", err_a, m_err);
    chk("sync_lost", lost_a, m_lost);
    chk("err_cnt", ecnt_a, m_ecnt);
    chk("bit_cnt", bcnt_a, m_bcnt);
    chk("locked_w4", locked_b, m_locked);
    chk("err_cnt_w4", ecnt_b, m_ecnt4);
    if (locked_a) lock_seen = 1'b1;
    if (err_a) err_seen++;
  endtask

  task automatic clean(input int n);
    bit b;
    for (int i = 0; i < n; i++) begin
      next_gen(b);
      cyc(1'b1, b, 1'b0, 1'b0);
    end
  endtask

  task automatic flipped(input bit clr);
    bit b;
    next_gen(b);
    cyc(1'b1, ~b, clr, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    g = 8'h01;
  endtask

  // Valid bits sent until locked is first seen; -1 if the cycle budget runs out.
  task automatic run_to_lock(input int duty, output int nv);
    bit b;
    nv = 0;
    for (int i = 0; i < 2000 && !locked_a; i++) begin
      if ($urandom_range(99) < duty) begin
        next_gen(b);
        cyc(1'b1, b, 1'b0, 1'b0);
        nv++;
      end else begin
        cyc(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
      end
    end
    if (!locked_a) nv = -1;
  endtask

  initial begin
    int         nv;
    bit         b;
    longint unsigned exp_bits;

    do_reset();
    chk("rst_locked", locked_a, 0);
    chk("rst_err_cnt", ecnt_a, 0);
    chk("rst_bit_cnt", bcnt_a, 0);
    $display("reset: locked=%0d err_cnt=%0d bit_cnt=%0d", locked_a, ecnt_a, bcnt_a);

    run_to_lock(100, nv);
    chk("lock_bits", nv, W + SYNC);
    clean(1000);
`ifdef PRBS_CHK_BITCNT_EN
    exp_bits = 1000;
`else
    exp_bits = 0;
`endif
    chk("lock_err_cnt", ecnt_a, 0);
    chk("lock_bit_cnt", bcnt_a, exp_bits);
    $display("lock: after %0d bits, err_cnt=%0d bit_cnt=%0d", nv, ecnt_a, bcnt_a);

    err_seen = 0;
    flipped(1'b0);
    clean(200);
    chk("single_pulses", err_seen, 1);
    chk("single_err_cnt", ecnt_a, 1);
    chk("single_locked", locked_a, 1);
    $display("single error: pulses=%0d err_cnt=%0d locked=%0d", err_seen, ecnt_a, locked_a);

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < LOSS; i++) flipped(1'b0);
    chk("loss_err_cnt", ecnt_a, LOSS);
    chk("loss_pulse", lost_a, 1);
    chk("loss_locked", locked_a, 0);
    run_to_lock(100, nv);
    chk("relock_bits", nv, W + SYNC);
    $display("loss: err_cnt=%0d relock after %0d bits", ecnt_a, nv);

    do_reset();
    lock_seen = 1'b0;
    err_seen  = 0;
    for (int i = 0; i < 500; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_lock", lock_seen, 0);
    chk("zero_err", err_seen, 0);
    $display("all-zero: lock_seen=%0d err_pulses=%0d", lock_seen, err_seen);

    do_reset();
    run_to_lock(30, nv);
    chk("gap_lock_bits", nv, W + SYNC);
    for (int k = 0; k < 2; k++) begin
      flipped(1'b0);
      clean(10);
    end
    flipped(1'b1);
    chk("clr_err_cnt", ecnt_a, 1);
    $display("gaps+clear: lock after %0d valid bits, err_cnt=%0d", nv, ecnt_a);

    for (int k = 0; k < 20; k++) begin
      flipped(1'b0);
      clean(5);
    end
    chk("sat_w4", ecnt_b, 15);
    clean(30);
    chk("sat_w4_hold", ecnt_b, 15);
    chk("sat_w16", ecnt_a, 21);
    $display("saturation: err_cnt_w4=%0d err_cnt=%0d", ecnt_b, ecnt_a);

    next_gen(b);
    cyc(1'b1, ~b, 1'b1, 1'b1);
    chk("midrst_locked", locked_a, 0);
    chk("midrst_err", err_a, 0);
    chk("midrst_lost", lost_a, 0);
    chk("midrst_err_cnt", ecnt_a, 0);
    chk("midrst_bit_cnt", bcnt_a, 0);
    $display("mid-stream reset: locked=%0d err_cnt=%0d", locked_a, ecnt_a);

    g = 8'h01;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 80) begin
        next_gen(b);
        if ($urandom_range(99) < 2) b = ~b;
        cyc(1'b1, b, ($urandom_range(99) < 1), 1'b0);
      end else begin
        cyc(1'b0, 1'($urandom_range(1)), ($urandom_range(99) < 1), 1'b0);
      end
    end
    $display("random soak: err_cnt=%0d locked=%0d", ecnt_a, locked_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
